// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI slave over a 2^MEM_AW x 32-bit SRAM with independent read and write FSMs.
// Optional macro AXI_SLV_BACKPRESSURE_EN gates every ready with a free-running toggle.
module axi_sram_slave #(
    parameter int MEM_AW = 10
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_t;
    typedef enum logic [2:0] {W_IDLE, W_GOTA, W_GOTD, W_COMMIT, W_RESP} w_state_t;

    r_state_t          r_state, r_next;
    w_state_t          w_state, w_next;
    logic [31:0]       mem [2**MEM_AW];
    logic [MEM_AW-1:0] r_idx, w_idx;
    logic [31:0]       w_data, w_merged;
    logic [3:0]        w_strb;
    logic              rdy_en, ar_hs, aw_hs, w_hs;
    logic              unused_ok;

`ifdef AXI_SLV_BACKPRESSURE_EN
    logic tog;
    // free-running toggle lets each ready be high at most every other cycle
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) tog <= 1'b0;
        else tog <= ~tog;
    assign rdy_en = tog;
`else
    assign rdy_en = 1'b1;
`endif

    assign arready = (r_state == R_IDLE) & rdy_en;
    assign awready = (w_state == W_IDLE || w_state == W_GOTD) & rdy_en;
    assign wready  = (w_state == W_IDLE || w_state == W_GOTA) & rdy_en;
    assign ar_hs   = arvalid & arready;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign rvalid  = (r_state == R_RESP);
    assign bvalid  = (w_state == W_RESP);
    assign rlast   = 1'b1;
    assign rresp   = 2'b00;
    assign bresp   = 2'b00;

    assign unused_ok = ^{arlen, arsize, arburst, arlock, arcache, arprot, awlen, awsize, awburst,
                         awlock, awcache, awprot, wid, wlast, araddr[31:MEM_AW+2], araddr[1:0],
                         awaddr[31:MEM_AW+2], awaddr[1:0]};

    // read FSM next state: accept address, fetch one cycle, hold response until rready
    always_comb begin
        r_next = (r_state == R_IDLE && ar_hs)  ? R_READ :
                 (r_state == R_READ)           ? R_RESP :
                 (r_state == R_RESP && rready) ? R_IDLE : r_state;
    end

    // write FSM next state: collect aw and w in either order, commit, then respond
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:   w_next = (aw_hs && w_hs) ? W_COMMIT : aw_hs ? W_GOTA : w_hs ? W_GOTD : W_IDLE;
            W_GOTA:   w_next = w_hs ? W_COMMIT : W_GOTA;
            W_GOTD:   w_next = aw_hs ? W_COMMIT : W_GOTD;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   w_next = bready ? W_IDLE : W_RESP;
            default:  w_next = W_IDLE;
        endcase
    end

    // byte-lane merge of the latched write data into the addressed word
    always_comb begin
        w_merged = mem[w_idx];
        for (int i = 0; i < 4; i++)
            if (w_strb[i]) w_merged[8*i +: 8] = w_data[8*i +: 8];
    end

    // read channel state and registers; a same-cycle commit to the read word wins
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            rid     <= '0;
            r_idx   <= '0;
            rdata   <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rid   <= arid;
                r_idx <= araddr[MEM_AW+1:2];
            end
            if (r_state == R_READ)
                rdata <= (w_state == W_COMMIT && w_idx == r_idx) ? w_merged : mem[r_idx];
        end
    end

    // write channel state and latched address, id, data and strobes
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            bid     <= '0;
            w_idx   <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                bid   <= awid;
                w_idx <= awaddr[MEM_AW+1:2];
            end
            if (w_hs) begin
                w_data <= wdata;
                w_strb <= wstrb;
            end
        end
    end

    // SRAM array is never reset; only a commit writes it
    always_ff @(posedge aclk)
        if (w_state == W_COMMIT) mem[w_idx] <= w_merged;
endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning log2 of the number of 32-bit memory words.
REQ-002 SHALL have port aclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have read-address inputs arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0] and arvalid, plus output arready.
REQ-005 SHALL have read-data outputs rid[3:0], rdata[31:0], rresp[1:0], rlast and rvalid, plus input rready.
REQ-006 SHALL have write-address inputs awid[3:0], awaddr[31:0], awlen[7:0], awsize[2:0], awburst[1:0], awlock[1:0], awcache[3:0], awprot[2:0] and awvalid, plus output awready.
REQ-007 SHALL have write-data inputs wid[3:0], wdata[31:0], wstrb[3:0], wlast and wvalid, plus output wready.
REQ-008 SHALL have write-response outputs bid[3:0], bresp[1:0] and bvalid, plus input bready.

Function
REQ-009 SHALL contain a memory of 2^MEM_AW 32-bit words, indexed by addr[MEM_AW+1:2]; upper address bits are ignored, so addresses wrap.
REQ-010 SHALL support single-beat transfers only, ignoring the len, size, burst, lock, cache and prot inputs and wlast.
REQ-011 SHALL drive rlast=1, rresp=2'b00 and bresp=2'b00 at all times.
REQ-012 SHALL run a read FSM with states R_IDLE -> R_READ -> R_RESP -> R_IDLE.
REQ-013 SHALL drive arready=1 only in R_IDLE; on arvalid&arready it SHALL latch arid and the word index and go to R_READ.
REQ-014 SHALL, in R_READ, read the memory word into a data register and go to R_RESP the next cycle.
REQ-015 SHALL, in R_RESP, hold rvalid=1 with rid equal to the latched arid and rdata stable until rready; on rvalid&rready it SHALL go to R_IDLE.
REQ-016 SHALL therefore give minimum read latency of 2 cycles from the ar handshake to rvalid, with at most one outstanding read.
REQ-017 SHALL run a write FSM with states W_IDLE, W_GOTA, W_GOTD, W_COMMIT and W_RESP.
REQ-018 SHALL, in W_IDLE, drive awready=1 and wready=1 and take these transitions:
- both handshakes in the same cycle -> W_COMMIT
- aw only -> W_GOTA
- w only -> W_GOTD
REQ-019 SHALL drive only wready=1 in W_GOTA and only awready=1 in W_GOTD; the missing handshake SHALL move the FSM to W_COMMIT.
REQ-020 SHALL latch awid and the word index on the aw handshake, and wdata and wstrb on the w handshake.
REQ-021 SHALL, in W_COMMIT, write each byte lane i where wstrb[i]=1, leave lanes with wstrb[i]=0 unchanged, and go to W_RESP.
REQ-022 SHALL, in W_RESP, hold bvalid=1 with bid equal to the latched awid until bready; on bvalid&bready it SHALL go to W_IDLE.
REQ-023 SHALL run the read and write FSMs independently.
REQ-024 SHALL, when R_READ and W_COMMIT target the same word in the same cycle, return the newly written data (write-first).
REQ-025 SHALL keep every output stable while its valid is high and not yet accepted.

Reset
REQ-026 SHALL, while aresetn=0, asynchronously force:
- both FSMs to idle
- arready=1, awready=1, wready=1
- rvalid=0, bvalid=0
- rid=0, bid=0, rdata=0
REQ-027 SHALL NOT reset memory contents.
REQ-028 SHALL, on reset asserted mid-transaction, abandon that transaction with no memory write and no response issued after reset release.

Configuration
REQ-029 SHALL, when macro AXI_SLV_BACKPRESSURE_EN is defined, AND arready, awready and wready with a free-running toggle bit that resets to 0, so each ready is high at most every other cycle.
REQ-030 SHALL, when AXI_SLV_BACKPRESSURE_EN is undefined, drive the ready signals purely per REQ-013/018/019, with timing and outputs identical to that behaviour.

Verification
REQ-031 SHALL cover: write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF in the same cycle, awid=1 -> bvalid 2 cycles later with bid=1; then read araddr=0x10, arid=1 -> rdata=0xDEADBEEF, rid=1, rlast=1.
REQ-032 SHALL cover: w handshake 3 cycles before aw for addr 0x20 -> exactly one write committed and one b response; memory at 0x20 updated.
REQ-033 SHALL cover: preload 0x20 with 0x11223344, write 0xAABBCCDD with wstrb=4'b0101 -> read returns 0x11BB33DD.
REQ-034 SHALL cover: rready held 0 for 5 cycles in R_RESP -> rvalid, rdata and rid stable throughout and arready=0 until acceptance.
REQ-035 SHALL cover: with MEM_AW=10, write address 0x1004 -> reading 0x0004 returns the same data (wrap).
REQ-036 SHALL cover: aresetn pulsed low while in W_GOTA -> no b response; memory unchanged; next transaction completes normally; with AXI_SLV_BACKPRESSURE_EN defined, ready is never high in two consecutive cycles.
